// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Contents: arbiter state encoding, header tag nibble, round-robin pointer step.
// No logic of its own; imported by uart_tx_arbiter and rr_picker.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    STREAM = 2'd2
  } arb_state_e;

  // Upper nibble of the per-frame tag byte; the lower nibble carries the grantee.
  localparam logic [3:0] HDR_TAG = 4'hA;

  // Advance a round-robin pointer by one, wrapping at n.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Purpose: combinational round-robin select, first set req_valid bit at or above rr_ptr (wrapping).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req_valid (N_REQ requests), rr_ptr (scan start) -> pick_valid, pick_id.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   rr_ptr,
  output logic             pick_valid,
  output logic [IDW-1:0]   pick_id
);

  int idx;

  // Scan from the farthest offset down to offset 0 so the candidate closest
  // to rr_ptr is the last one written and therefore wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: frame-granular round-robin sharing of one UART TX path among N_REQ byte streams.
// Latency: 1 idle arbitration cycle before the first byte (2 with the tag header); STREAM data path is combinational.
// Backpressure: Full stalls HEADER and STREAM indefinitely; a grantee idle for STALL_TIMEOUT cycles is revoked with abort.
// Ports: Clk, Reset (sync, active-high); req_valid/req_data/req_last in, req_ready out;
//        Full in; TX_data, wr_uart_en out; grant_id, busy, abort status out.
// Build option: define UART_TX_ARB_ID_HEADER_EN to prefix every frame with tag byte {HDR_TAG, grant_id}.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_BITS     = 8,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       Full,
  output logic [DATA_BITS-1:0]       TX_data,
  output logic                       wr_uart_en,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       abort
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int CNTW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  // The abort fires on the idle cycle that would bring the count to STALL_TIMEOUT.
  localparam logic [CNTW-1:0] STALL_LIM = (STALL_TIMEOUT > 0) ? CNTW'(STALL_TIMEOUT - 1) : '0;

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  logic            pick_valid;
  logic [IDW-1:0]  pick_id;
  logic            grant_vld;
  logic            grant_last;

  rr_picker #(.N_REQ(N_REQ), .IDW(IDW)) u_picker (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr_q),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  assign grant_vld  = req_valid[grant_q];
  assign grant_last = req_last[grant_q];
  assign grant_id   = grant_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    stall_cnt_d = stall_cnt_q;
    req_ready   = '0;
    TX_data     = '0;
    wr_uart_en  = 1'b0;
    busy        = 1'b0;
    abort       = 1'b0;

    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (pick_valid) begin
          grant_d = pick_id;
`ifdef UART_TX_ARB_ID_HEADER_EN
          state_d = HEADER;
`else
          state_d = STREAM;
`endif
        end
      end

`ifdef UART_TX_ARB_ID_HEADER_EN
      HEADER: begin
        busy = 1'b1;
        if (!Full) begin
          wr_uart_en = 1'b1;
          TX_data    = DATA_BITS'({HDR_TAG, 4'(grant_q)});
          state_d    = STREAM;
        end
      end
`endif

      STREAM: begin
        busy               = 1'b1;
        req_ready[grant_q] = !Full;
        TX_data            = req_data[int'(grant_q)*DATA_BITS +: DATA_BITS];
        wr_uart_en         = grant_vld && !Full;
        if (grant_vld) begin
          // A valid byte blocked by Full is not a stall: the counter holds.
          if (!Full) begin
            stall_cnt_d = '0;
            if (grant_last) begin
              rr_ptr_d = IDW'(next_ptr(32'(grant_q), 32'(N_REQ)));
              state_d  = IDLE;
            end
          end
        end else if (STALL_TIMEOUT != 0) begin
          if (stall_cnt_q == STALL_LIM) begin
            // Revoke the grant; bytes already sent stay on the line.
            abort       = 1'b1;
            rr_ptr_d    = IDW'(next_ptr(32'(grant_q), 32'(N_REQ)));
            stall_cnt_d = '0;
            state_d     = IDLE;
          end else begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: directed frames queued per requester,
// expected TX bytes / grantees / abort timing pushed at issue time and
// popped by a negedge monitor.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 8;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [N-1:0]    req_valid;
  logic [N*DB-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            Full;
  logic [DB-1:0]   TX_data;
  logic            wr_uart_en;
  logic [1:0]      grant_id;
  logic            busy;
  logic            abort;

  uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DB), .STALL_TIMEOUT(TO)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .Full       (Full),
    .TX_data    (TX_data),
    .wr_uart_en (wr_uart_en),
    .grant_id   (grant_id),
    .busy       (busy),
    .abort      (abort)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } byte_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] id;
  } exp_t;

  byte_t req_q [N][$];
  exp_t  exp_q[$];
  int    exp_abort_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_tx_cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Queue a frame of n bytes for requester id; term=0 leaves the last byte unmarked.
  task automatic send(input int id, input int n, input bit term,
                      input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bs [3];
    exp_t e;
    bs = '{b0, b1, b2};
`ifdef UART_TX_ARB_ID_HEADER_EN
    e.d  = {4'hA, 4'(id)};
    e.id = 2'(id);
    exp_q.push_back(e);
`endif
    for (int k = 0; k < n; k++) begin
      req_q[id].push_back('{d: bs[k], l: (term && (k == n - 1))});
      e.d  = bs[k];
      e.id = 2'(id);
      exp_q.push_back(e);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() != 0) || (exp_abort_q.size() != 0);
    for (int i = 0; i < N; i++) if (req_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(pending()), 32'd0);
  endtask

  // Requester model: presents queue heads just after each rising edge,
  // pops whatever handshook on the edge before.
  initial begin
    logic [N-1:0] fired;
    fired     = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge Clk);
      #1;
      for (int i = 0; i < N; i++)
        if (fired[i] && req_q[i].size() != 0) void'(req_q[i].pop_front());
      for (int i = 0; i < N; i++) begin
        if (req_q[i].size() != 0) begin
          req_valid[i]          = 1'b1;
          req_data[i*DB +: DB]  = req_q[i][0].d;
          req_last[i]           = req_q[i][0].l;
        end else begin
          req_valid[i]          = 1'b0;
          req_data[i*DB +: DB]  = '0;
          req_last[i]           = 1'b0;
        end
      end
      @(negedge Clk);
      fired = req_valid & req_ready & {N{!Reset}};
    end
  end

  // Monitor: every TX write and every abort must match the scoreboard.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Full) check("no_write_when_full", 32'(wr_uart_en), 32'd0);
      if (wr_uart_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tx_byte", 32'(TX_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tx_data", 32'(TX_data), 32'(e.d));
          check("grant_id", 32'(grant_id), 32'(e.id));
        end
        last_tx_cyc = cyc;
      end
      if (abort) begin
        if (exp_abort_q.size() == 0) begin
          check("unexpected_abort", 32'(abort), 32'd0);
        end else begin
          int dly;
          dly = exp_abort_q.pop_front();
          check("abort_delay", 32'(cyc - last_tx_cyc), 32'(dly));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1;
    Full  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_wr_en", 32'(wr_uart_en), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_data", 32'(TX_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    Reset = 1'b0;
    tick();

    // All four requesters at once: served 0,1,2,3.
    send(0, 1, 1'b1, 8'h11, 8'h00, 8'h00);
    send(1, 1, 1'b1, 8'h22, 8'h00, 8'h00);
    send(2, 1, 1'b1, 8'h33, 8'h00, 8'h00);
    send(3, 1, 1'b1, 8'h44, 8'h00, 8'h00);
    drain("rr_four_drain", 100);

    // Requester 1 raises valid while requester 2 is mid-frame: no interleave.
    send(2, 3, 1'b1, 8'hA1, 8'hA2, 8'hA3);
    tick();
    tick();
    send(1, 2, 1'b1, 8'h61, 8'h62, 8'h00);
    drain("no_interleave_drain", 100);

    // Full held for 10 cycles mid-frame.
    send(3, 3, 1'b1, 8'hC1, 8'hC2, 8'hC3);
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    check("full_frame_started", 32'(busy), 32'd1);
    tick();
    Full = 1'b1;
    repeat (10) begin
      tick();
      check("busy_in_full", 32'(busy), 32'd1);
    end
    Full = 1'b0;
    drain("full_resume_drain", 100);

    // Grantee 0 stalls after one byte: abort 8 cycles later, requester 1 next.
    send(0, 1, 1'b0, 8'h01, 8'h00, 8'h00);
    send(1, 1, 1'b1, 8'h77, 8'h00, 8'h00);
    exp_abort_q.push_back(TO);
    drain("stall_abort_drain", 100);

    // Reset mid-frame of requester 2 (pointer is 2 going in).
    send(2, 1, 1'b0, 8'hB1, 8'h00, 8'h00);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("pre_reset_byte_sent", 32'(exp_q.size()), 32'd0);
    tick();
    Reset = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_abort", 32'(abort), 32'd0);
    check("midrst_wr_en", 32'(wr_uart_en), 32'd0);
    Reset = 1'b0;
    // Pointer back at 0: requester 0 beats requester 3.
    send(0, 1, 1'b1, 8'h0A, 8'h00, 8'h00);
    send(3, 1, 1'b1, 8'h3A, 8'h00, 8'h00);
    drain("post_reset_drain", 100);

    // Single byte from requester 3 (tagged 0xA3 first when headers are built in).
    send(3, 1, 1'b1, 8'h55, 8'h00, 8'h00);
    drain("single_byte_drain", 100);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-granular round-robin arbiter sharing the single UART transmit path between `N_REQ` byte-stream requesters. Sits directly in front of the `UART` block's TX side: drives `TX_data`/`wr_uart_en` and obeys `Full`. A requester that wins the grant keeps it until its frame's last byte is accepted, so frames from different requesters never interleave on the TX line.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `DATA_BITS`, 8: byte width; must match the UART `C_DATA_BITS`.
- `STALL_TIMEOUT`, 1024: idle cycles tolerated mid-frame before the grant is revoked; 0 disables the timeout.

- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester byte valid.
- `req_data`  in  N_REQ*DATA_BITS  flattened bytes; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- `req_last`  in  N_REQ  marks the final byte of a frame.
- `req_ready`  out  N_REQ  per-requester byte accepted.
- `Full`  in  1  UART TX FIFO full.
- `TX_data`  out  DATA_BITS  byte to the UART.
- `wr_uart_en`  out  1  UART write strobe.
- `grant_id`  out  $clog2(N_REQ)  current or most recent grantee.
- `busy`  out  1  frame in progress.
- `abort`  out  1  one-cycle pulse when a stalled frame is revoked.

## Operation
- The FSM has three states: IDLE, HEADER (only when the macro is defined), and STREAM.
- **IDLE**
  - If any `req_valid` is set, select the first set bit scanning upward from `rr_ptr`, wrapping modulo `N_REQ`.
  - Register the winner into `grant_id`.
  - Go to HEADER if the macro is defined, otherwise to STREAM.
  - No byte is transferred in IDLE.
- **HEADER**
  - While `Full`=0: `wr_uart_en`=1 and `TX_data`={4'hA, grant_id zero-extended to 4 bits}; then go to STREAM.
  - While `Full`=1: stay in HEADER.
- **STREAM**
  - `req_ready[grant_id]` = !`Full`; every other `req_ready` bit = 0.
  - `wr_uart_en` = `req_valid[grant_id]` & !`Full`.
  - `TX_data` = `req_data` slice of `grant_id`.
  - When the transfer occurs with `req_last[grant_id]`=1: `rr_ptr` ← (grant_id+1) mod N_REQ, then go to IDLE.
- **Stall counter**
  - Clears on every transfer; increments each STREAM cycle with `req_valid[grant_id]`=0.
  - When it reaches `STALL_TIMEOUT` (nonzero): pulse `abort`, advance `rr_ptr` as on last, go to IDLE. Bytes already written are not recalled.
- `busy` = 1 in HEADER and STREAM.
- `Full` stalls both HEADER and STREAM without limit. The stall counter does not advance while `req_valid[grant_id]`=1 and `Full`=1.
- `wr_uart_en` is never asserted in a cycle where `Full`=1.

## Timing
- **Reset values**
  - State IDLE; `rr_ptr`=0; `grant_id`=0; stall counter=0.
  - `busy`=0, `abort`=0, `wr_uart_en`=0, `req_ready`=0, `TX_data`=0.
- **Latency**
  - Arbitration: 1 cycle from `req_valid` to the first possible transfer (2 cycles with the header).
  - Data path in STREAM is combinational: `req_valid`/`req_data`/`Full` reach `wr_uart_en`/`TX_data`/`req_ready` in the same cycle.
- **Frame gaps**
  - Minimum one IDLE cycle between consecutive frames.
  - A single-byte frame (valid and last together) completes in one STREAM cycle.
- **Handshake:** a byte moves on the edge where `req_valid[i]` & `req_ready[i]`. Requesters must hold data stable until ready.
- **Mid-frame reset:** returns to IDLE on the next edge; the partial frame is dropped with no `abort` pulse.
- **Simultaneous events**
  - A requester asserting valid while another holds the grant waits.
  - Pointer wrap: `rr_ptr`=N_REQ-1 with grantee N_REQ-1 yields `rr_ptr`=0.

## Configuration
- `UART_TX_ARB_ID_HEADER_EN`
  - Defined: HEADER state exists; every frame is prefixed on the TX line with tag byte 0xA0|grant_id.
  - Undefined: HEADER is omitted; IDLE goes directly to STREAM, and the TX line carries requester bytes only.

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum `arb_state_e` (IDLE, HEADER, STREAM);
  - `HDR_TAG` = 4'hA;
  - the function `next_ptr(ptr, n)`.
- One sub-module, `rr_picker`: combinational `N_REQ`-wide round-robin priority select.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: `pick_valid`, `pick_id`.

## Test plan
- After reset, all four requesters assert valid with 1-byte frames 0x11/0x22/0x33/0x44. TX order is 0x11, 0x22, 0x33, 0x44; `grant_id` steps 0, 1, 2, 3.
- Requester 2 sends a 3-byte frame 0xA1, 0xA2, 0xA3 while requester 1 raises valid mid-frame. Requester 1's bytes appear only after 0xA3; there is no interleave.
- `Full` is held high for 10 cycles mid-frame. `wr_uart_en` stays 0 throughout, `abort` stays 0, and the frame resumes intact.
- With `STALL_TIMEOUT`=8, the grantee drops valid after 1 byte. `abort` pulses exactly 8 cycles later, and the next requester is granted.
- `Reset` is asserted mid-frame. The next cycle shows `busy`=0, `req_ready`=0, `rr_ptr`=0; a fresh request from requester 0 is served first.
- With `UART_TX_ARB_ID_HEADER_EN` defined, requester 3 sends 0x55 (last). The TX bytes are 0xA3 then 0x55.
